// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU control, ALU B-mux select.
// Latency: none (constants and types only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    // Primary opcode field values (IR[31:26]) recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // ALU control class handed to the ALU decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

    // ALU B-input mux select
    localparam logic [1:0] ALUSRCB_REG  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

    // Instruction class produced by the opcode decoder; drives the DECODE dispatch
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_I   = 3'd4,
        CLS_ILL = 3'd5
    } op_class_t;

endpackage

// File: rtl/ctrl_opdec.sv
// Opcode decoder: opcode -> instruction class, immediate-extension mode, logic-op flag.
// Latency: purely combinational.
// Backpressure: none; outputs are only consumed in the DECODE state.
module ctrl_opdec
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] i_opcode,
    output op_class_t      o_cls,
    output logic           o_ext_sel,
    output logic           o_ext_vld,
    output logic           o_is_logic
);

    // Classify the opcode; o_ext_vld=0 means the extension mode must be left untouched
    always_comb begin
        o_cls      = CLS_ILL;
        o_ext_sel  = 1'b1;
        o_ext_vld  = 1'b0;
        o_is_logic = 1'b0;
        case (i_opcode)
            OPW'(OP_RTYPE): o_cls = CLS_R;
            OPW'(OP_LW): begin
                o_cls     = CLS_LW;
                o_ext_vld = 1'b1;
            end
            OPW'(OP_SW): begin
                o_cls     = CLS_SW;
                o_ext_vld = 1'b1;
            end
            OPW'(OP_BEQ): begin
                o_cls     = CLS_BR;
                o_ext_vld = 1'b1;
            end
            OPW'(OP_ADDI): begin
                o_cls     = CLS_I;
                o_ext_vld = 1'b1;
            end
            OPW'(OP_ANDI), OPW'(OP_ORI): begin
                o_cls      = CLS_I;
                o_ext_sel  = 1'b0;
                o_ext_vld  = 1'b1;
                o_is_logic = 1'b1;
            end
            default: o_cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Latency: 3-5 cycles per instruction with memory ready; FETCH/MEM_RD/MEM_WR stall on mem_ready.
// Backpressure: mem_ready low holds the FSM in the current memory state; rst aborts any access.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           ir_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           branch,
    output logic           ext_sel,
    output logic           illegal,
    output logic [STW-1:0] state
);

    // State codes are visible on the debug port, so the numbering is fixed
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_WB_R    = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_RD  = 4'd5,
        S_WB_MEM  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_EXEC_I  = 4'd9,
        S_WB_I    = 4'd10,
        S_ILLEGAL = 4'd11
    } state_t;

    state_t    r_state;
    state_t    w_next;
    // Set for the single cycle after a reset edge: outputs quiet, FSM parked in FETCH
    logic      r_rst_hold;
    logic      r_ext_sel;
    // Opcode-derived facts captured at DECODE so later states never look at the live opcode
    logic      r_is_store;
    logic      r_is_logic;

    op_class_t w_cls;
    logic      w_ext_sel;
    logic      w_ext_vld;
    logic      w_is_logic;

    ctrl_opdec #(
        .OPW (OPW)
    ) u_opdec (
        .i_opcode   (opcode),
        .o_cls      (w_cls),
        .o_ext_sel  (w_ext_sel),
        .o_ext_vld  (w_ext_vld),
        .o_is_logic (w_is_logic)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_rst_hold <= 1'b0;
        end
    end

    // Capture extension mode and per-instruction flags on the DECODE edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_sel  <= 1'b1;
            r_is_store <= 1'b0;
            r_is_logic <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_is_store <= (w_cls == CLS_SW);
            r_is_logic <= w_is_logic;
            if (w_ext_vld) begin
                r_ext_sel <= w_ext_sel;
            end
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = ALUSRCB_REG;
        alu_op     = ALU_OP_ADD;
        branch     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                alu_op    = ALU_OP_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    CLS_R:          w_next = S_EXEC_R;
                    CLS_LW, CLS_SW: w_next = S_ADDR;
                    CLS_BR:         w_next = S_BRANCH;
                    CLS_I:          w_next = S_EXEC_I;
                    default:        w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_b = ALUSRCB_REG;
                alu_op    = ALU_OP_FUNCT;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDR: begin
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALU_OP_ADD;
                w_next    = r_is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_b = ALUSRCB_REG;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
                w_next    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_b = ALUSRCB_IMM;
                alu_op    = r_is_logic ? ALU_OP_LOGIC : ALU_OP_ADD;
                w_next    = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // The cycle right after reset is quiet regardless of what FETCH would assert
        if (r_rst_hold) begin
            w_next     = S_FETCH;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_b  = ALUSRCB_REG;
            alu_op     = ALU_OP_ADD;
            branch     = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign ext_sel = r_ext_sel;
    assign state   = STW'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction stream vs a trace model.
// Latency: n/a.
// Backpressure: mem_ready stalls are generated by the bench.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] alu_src_b, alu_op;
    logic       branch, ext_sel, illegal;
    logic [3:0] state;

    int n_chk  = 0;
    int n_fail = 0;
    logic m_ext;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPW(6), .STW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .branch     (branch),
        .ext_sel    (ext_sel),
        .illegal    (illegal),
        .state      (state)
    );

    logic [12:0] outs;
    assign outs = {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_b, alu_op, branch, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h08 || op == 6'h0C || op == 6'h0D;
    endfunction

    // Expected control vector per state, straight from the state table
    function automatic logic [12:0] exp_outs(input int st, input bit mr, input bit lg);
        logic [12:0] v;
        v = '0;
        case (st)
            0:  v = {mr, mr, 1'b1, 4'b0000, 2'b01, 2'b00, 2'b00};
            2:  v = {7'b0, 2'b00, 2'b10, 2'b00};
            3:  v = {4'b0000, 1'b1, 1'b1, 1'b0, 6'b0};
            4:  v = {7'b0, 2'b10, 2'b00, 2'b00};
            5:  v = {2'b00, 1'b1, 10'b0};
            6:  v = {4'b0000, 1'b1, 1'b0, 1'b1, 6'b0};
            7:  v = {3'b000, 1'b1, 9'b0};
            8:  v = {7'b0, 2'b00, 2'b01, 2'b10};
            9:  v = {7'b0, 2'b10, (lg ? 2'b11 : 2'b00), 2'b00};
            10: v = {4'b0000, 1'b1, 8'b0};
            11: v = 13'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Build the cycle-by-cycle state trace for one instruction, then walk it
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int st_q[$];
        bit mr_q[$];
        bit lg;
        lg = (op == 6'h0C) || (op == 6'h0D);
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        if (op == 6'h00) begin
            st_q.push_back(2); mr_q.push_back(1'($urandom));
            st_q.push_back(3); mr_q.push_back(1'($urandom));
        end else if (op == 6'h23 || op == 6'h2B) begin
            int ms;
            ms = (op == 6'h23) ? 5 : 7;
            st_q.push_back(4); mr_q.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin st_q.push_back(ms); mr_q.push_back(1'b0); end
            st_q.push_back(ms); mr_q.push_back(1'b1);
            if (op == 6'h23) begin st_q.push_back(6); mr_q.push_back(1'($urandom)); end
        end else if (op == 6'h04) begin
            st_q.push_back(8); mr_q.push_back(1'($urandom));
        end else if (op == 6'h08 || lg) begin
            st_q.push_back(9); mr_q.push_back(1'($urandom));
            st_q.push_back(10); mr_q.push_back(1'($urandom));
        end else begin
            st_q.push_back(11); mr_q.push_back(1'($urandom));
        end
        for (int k = 0; k < st_q.size(); k++) begin
            mem_ready = mr_q[k];
            opcode    = (st_q[k] == 1) ? op : 6'($urandom);
            #2;
            chk("state", 32'(state), 32'(st_q[k]));
            chk("ctrl", 32'(outs), 32'(exp_outs(st_q[k], mr_q[k], lg)));
            chk("ext_sel", 32'(ext_sel), 32'(m_ext));
            if (st_q[k] == 1) begin
                if (op == 6'h0C || op == 6'h0D) m_ext = 1'b0;
                else if (is_legal(op) && op != 6'h00) m_ext = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] legal_ops [7];
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D};

        // Reset held two clocks with LW on the opcode bus
        rst = 1'b1; opcode = 6'h23; mem_ready = 1'b0;
        m_ext = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_ext", 32'(ext_sel), 32'd1);
            chk("rst_ctrl", 32'(outs), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_mem_read", 32'(mem_read), 32'd1);

        // Directed: R-type, LW with 3 memory stalls, ADDI then ANDI, illegal
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 1, 3);
        run_instr(6'h08, 0, 0);
        run_instr(6'h0C, 0, 0);
        run_instr(6'h3F, 0, 0);

        // SW aborted by reset while waiting in MEM_WR
        mem_ready = 1'b1; opcode = 6'h2B;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        chk("sw_wait_state", 32'(state), 32'd7);
        chk("sw_wait_mem_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_ctrl", 32'(outs), 32'd0);
        chk("abort_ext", 32'(ext_sel), 32'd1);
        m_ext = 1'b1;
        @(posedge clk); #1;

        // Random instruction stream with random stalls
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
